// File: rtl/sa_read_channel_pkg.sv
// Shared helpers for the slave-side read channel: index-width derivation and
// modulo increment used by the round-robin pointer.
package sa_read_channel_pkg;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int wrap_inc(input int v, input int m);
      return (v + 1 >= m) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/sa_read_channel_if.sv
// Bundle of dispatcher-side and slave-side AR/R signals for one slave port.
// The block itself uses the slave modport; the surrounding fabric uses master.
interface sa_read_channel_if #(
   parameter int MST_AMT           = 2,
   parameter int DATA_WIDTH        = 32,
   parameter int ADDR_WIDTH        = 32,
   parameter int TRANS_MST_ID_W    = 5,
   parameter int TRANS_BURST_W     = 2,
   parameter int TRANS_DATA_LEN_W  = 3,
   parameter int TRANS_DATA_SIZE_W = 3
) ();
   logic [MST_AMT*TRANS_MST_ID_W-1:0]    dsp_ARID_i;
   logic [MST_AMT*ADDR_WIDTH-1:0]        dsp_ARADDR_i;
   logic [MST_AMT*TRANS_BURST_W-1:0]     dsp_ARBURST_i;
   logic [MST_AMT*TRANS_DATA_LEN_W-1:0]  dsp_ARLEN_i;
   logic [MST_AMT*TRANS_DATA_SIZE_W-1:0] dsp_ARSIZE_i;
   logic [MST_AMT-1:0]                   dsp_ARVALID_i;
   logic [MST_AMT-1:0]                   dsp_ARREADY_o;
   logic [TRANS_MST_ID_W-1:0]            dsp_RID_o;
   logic [DATA_WIDTH-1:0]                dsp_RDATA_o;
   logic                                 dsp_RLAST_o;
   logic [MST_AMT-1:0]                   dsp_RVALID_o;
   logic [MST_AMT-1:0]                   dsp_RREADY_i;

   logic [TRANS_MST_ID_W-1:0]            s_ARID_o;
   logic [ADDR_WIDTH-1:0]                s_ARADDR_o;
   logic [TRANS_BURST_W-1:0]             s_ARBURST_o;
   logic [TRANS_DATA_LEN_W-1:0]          s_ARLEN_o;
   logic [TRANS_DATA_SIZE_W-1:0]         s_ARSIZE_o;
   logic                                 s_ARVALID_o;
   logic                                 s_ARREADY_i;
   logic [TRANS_MST_ID_W-1:0]            s_RID_i;
   logic [DATA_WIDTH-1:0]                s_RDATA_i;
   logic                                 s_RLAST_i;
   logic                                 s_RVALID_i;
   logic                                 s_RREADY_o;

   modport slave (
      input  dsp_ARID_i, dsp_ARADDR_i, dsp_ARBURST_i, dsp_ARLEN_i, dsp_ARSIZE_i,
             dsp_ARVALID_i, dsp_RREADY_i, s_ARREADY_i, s_RID_i, s_RDATA_i,
             s_RLAST_i, s_RVALID_i,
      output dsp_ARREADY_o, dsp_RID_o, dsp_RDATA_o, dsp_RLAST_o, dsp_RVALID_o,
             s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o,
             s_ARVALID_o, s_RREADY_o
   );

   modport master (
      output dsp_ARID_i, dsp_ARADDR_i, dsp_ARBURST_i, dsp_ARLEN_i, dsp_ARSIZE_i,
             dsp_ARVALID_i, dsp_RREADY_i, s_ARREADY_i, s_RID_i, s_RDATA_i,
             s_RLAST_i, s_RVALID_i,
      input  dsp_ARREADY_o, dsp_RID_o, dsp_RDATA_o, dsp_RLAST_o, dsp_RVALID_o,
             s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o,
             s_ARVALID_o, s_RREADY_o
   );
endinterface

// File: rtl/sa_order_fifo.sv
// In-order tracking FIFO of granted master indices; head selects where the
// current R burst is steered.
module sa_order_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 1,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [W-1:0]     din_i,
   input  logic             pop_i,
   output logic [W-1:0]     head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_d  = do_push ? inc(wr_q) : wr_q;
      rd_d  = do_pop  ? inc(rd_q) : rd_q;
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (do_push) mem_q[wr_q] <= din_i;
      end
   end
endmodule

// File: rtl/sa_read_channel.sv
// Slave-port read arbiter: round-robin AR grant into a one-entry output
// register, in-order tracking of grants, and R steering to the head master.
module sa_read_channel
   import sa_read_channel_pkg::*;
#(
   parameter int MST_AMT           = 2,
   parameter int OUTSTANDING_AMT   = 8,
   parameter int DATA_WIDTH        = 32,
   parameter int ADDR_WIDTH        = 32,
   parameter int TRANS_MST_ID_W    = 5,
   parameter int TRANS_BURST_W     = 2,
   parameter int TRANS_DATA_LEN_W  = 3,
   parameter int TRANS_DATA_SIZE_W = 3,
   parameter int MST_ID_W          = idx_w(MST_AMT)
) (
   input  logic             ACLK_i,
   input  logic             ARESETn_i,
   sa_read_channel_if.slave bus
);
   localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

   logic [MST_AMT-1:0][TRANS_MST_ID_W-1:0]    id_v;
   logic [MST_AMT-1:0][ADDR_WIDTH-1:0]        addr_v;
   logic [MST_AMT-1:0][TRANS_BURST_W-1:0]     burst_v;
   logic [MST_AMT-1:0][TRANS_DATA_LEN_W-1:0]  len_v;
   logic [MST_AMT-1:0][TRANS_DATA_SIZE_W-1:0] size_v;

   logic [MST_ID_W-1:0]          rr_q, rr_d, cand, gnt_idx, head;
   logic [CNT_W-1:0]             count;
   logic                         found, grant, load_ok, full, empty, rready, pop;
   logic                         arvalid_q, arvalid_d;
   logic [TRANS_MST_ID_W-1:0]    arid_q, arid_d;
   logic [ADDR_WIDTH-1:0]        araddr_q, araddr_d;
   logic [TRANS_BURST_W-1:0]     arburst_q, arburst_d;
   logic [TRANS_DATA_LEN_W-1:0]  arlen_q, arlen_d;
   logic [TRANS_DATA_SIZE_W-1:0] arsize_q, arsize_d;

   assign id_v    = bus.dsp_ARID_i;
   assign addr_v  = bus.dsp_ARADDR_i;
   assign burst_v = bus.dsp_ARBURST_i;
   assign len_v   = bus.dsp_ARLEN_i;
   assign size_v  = bus.dsp_ARSIZE_i;

   // First requester at or after the pointer wins.
   always_comb begin
      found   = 1'b0;
      cand    = '0;
      gnt_idx = '0;
      for (int i = 0; i < MST_AMT; i++) begin
         cand = MST_ID_W'((int'(rr_q) + i) % MST_AMT);
         if (!found && bus.dsp_ARVALID_i[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign load_ok           = ~arvalid_q | bus.s_ARREADY_i;
   assign grant             = load_ok & ~full & found;
   assign bus.dsp_ARREADY_o = grant ? (MST_AMT'(1) << gnt_idx) : '0;
   assign rr_d              = grant ? MST_ID_W'(wrap_inc(int'(gnt_idx), MST_AMT)) : rr_q;

   always_comb begin
      arvalid_d = arvalid_q;
      arid_d    = arid_q;
      araddr_d  = araddr_q;
      arburst_d = arburst_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      if (grant) begin
         arvalid_d = 1'b1;
         arid_d    = id_v[gnt_idx];
         araddr_d  = addr_v[gnt_idx];
         arburst_d = burst_v[gnt_idx];
         arlen_d   = len_v[gnt_idx];
         arsize_d  = size_v[gnt_idx];
      end else if (bus.s_ARREADY_i) begin
         arvalid_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         rr_q      <= '0;
         arvalid_q <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arburst_q <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
      end else begin
         rr_q      <= rr_d;
         arvalid_q <= arvalid_d;
         arid_q    <= arid_d;
         araddr_q  <= araddr_d;
         arburst_q <= arburst_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
      end
   end

   assign bus.s_ARVALID_o = arvalid_q;
   assign bus.s_ARID_o    = arid_q;
   assign bus.s_ARADDR_o  = araddr_q;
   assign bus.s_ARBURST_o = arburst_q;
   assign bus.s_ARLEN_o   = arlen_q;
   assign bus.s_ARSIZE_o  = arsize_q;

   // With no outstanding grant the slave is held off rather than misrouted.
   assign rready           = bus.dsp_RREADY_i[head] & ~empty;
   assign pop              = bus.s_RVALID_i & rready & bus.s_RLAST_i;
   assign bus.s_RREADY_o   = rready;
   assign bus.dsp_RVALID_o = (bus.s_RVALID_i & ~empty) ? (MST_AMT'(1) << head) : '0;
   assign bus.dsp_RID_o    = bus.s_RID_i;
   assign bus.dsp_RDATA_o  = bus.s_RDATA_i;
   assign bus.dsp_RLAST_o  = bus.s_RLAST_i;

   sa_order_fifo #(.DEPTH(OUTSTANDING_AMT), .W(MST_ID_W), .CNT_W(CNT_W)) u_fifo (
      .clk_i  (ACLK_i),
      .rst_ni (ARESETn_i),
      .push_i (grant),
      .din_i  (gnt_idx),
      .pop_i  (pop),
      .head_o (head),
      .count_o(count),
      .full_o (full),
      .empty_o(empty)
   );

   a_full_tracks_count: assert property (@(posedge ACLK_i) disable iff (!ARESETn_i)
      full == (count == CNT_W'(OUTSTANDING_AMT)));
endmodule

// File: tb/tb_sa_read_channel.sv
// Directed bench for sa_read_channel with a queue-based reference model and
// per-cycle comparison of all outputs.
module tb_sa_read_channel;
   logic clk, rst_n;
   int   total = 0;
   int   bad   = 0;

   sa_read_channel_if bus ();
   sa_read_channel dut (.ACLK_i(clk), .ARESETn_i(rst_n), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: queue of granted masters, rr pointer, AR output slot.
   bit          mq[$];
   bit          m_rr  = 1'b0;
   bit          m_arv = 1'b0;
   logic [4:0]  m_id    = '0;
   logic [31:0] m_addr  = '0;
   logic [1:0]  m_burst = '0;
   logic [2:0]  m_len   = '0;
   logic [2:0]  m_size  = '0;

   function automatic logic [1:0] onehot(input bit g);
      return g ? 2'b10 : 2'b01;
   endfunction

   function automatic void m_pick(output bit ok, output bit g);
      ok = 1'b0;
      g  = 1'b0;
      if (mq.size() < 8 && (!m_arv || bus.s_ARREADY_i)) begin
         if (bus.dsp_ARVALID_i[m_rr]) begin
            ok = 1'b1; g = m_rr;
         end else if (bus.dsp_ARVALID_i[~m_rr]) begin
            ok = 1'b1; g = ~m_rr;
         end
      end
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete();
         m_rr = 1'b0; m_arv = 1'b0;
         m_id = '0; m_addr = '0; m_burst = '0; m_len = '0; m_size = '0;
      end else begin
         bit ok, g, popv;
         m_pick(ok, g);
         popv = bus.s_RVALID_i && mq.size() > 0 && bus.s_RLAST_i && bus.dsp_RREADY_i[mq[0]];
         if (popv) void'(mq.pop_front());
         if (ok) begin
            mq.push_back(g);
            m_arv   = 1'b1;
            m_id    = g ? bus.dsp_ARID_i[9:5]     : bus.dsp_ARID_i[4:0];
            m_addr  = g ? bus.dsp_ARADDR_i[63:32] : bus.dsp_ARADDR_i[31:0];
            m_burst = g ? bus.dsp_ARBURST_i[3:2]  : bus.dsp_ARBURST_i[1:0];
            m_len   = g ? bus.dsp_ARLEN_i[5:3]    : bus.dsp_ARLEN_i[2:0];
            m_size  = g ? bus.dsp_ARSIZE_i[5:3]   : bus.dsp_ARSIZE_i[2:0];
            m_rr    = ~g;
         end else if (bus.s_ARREADY_i) begin
            m_arv = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
         bit ok, g;
         logic [1:0] er, ev;
         logic es;
         m_pick(ok, g);
         er = ok ? onehot(g) : 2'b00;
         ev = 2'b00;
         es = 1'b0;
         if (mq.size() > 0) begin
            es = bus.dsp_RREADY_i[mq[0]];
            if (bus.s_RVALID_i) ev = onehot(mq[0]);
         end
         check("arready", 64'(bus.dsp_ARREADY_o), 64'(er));
         check("s_arvalid", 64'(bus.s_ARVALID_o), 64'(m_arv));
         check("s_arid", 64'(bus.s_ARID_o), 64'(m_id));
         check("s_araddr", 64'(bus.s_ARADDR_o), 64'(m_addr));
         check("s_arburst", 64'(bus.s_ARBURST_o), 64'(m_burst));
         check("s_arlen", 64'(bus.s_ARLEN_o), 64'(m_len));
         check("s_arsize", 64'(bus.s_ARSIZE_o), 64'(m_size));
         check("rvalid", 64'(bus.dsp_RVALID_o), 64'(ev));
         check("s_rready", 64'(bus.s_RREADY_o), 64'(es));
         check("rdata", 64'(bus.dsp_RDATA_o), 64'(bus.s_RDATA_i));
         check("rid", 64'(bus.dsp_RID_o), 64'(bus.s_RID_i));
         check("rlast", 64'(bus.dsp_RLAST_o), 64'(bus.s_RLAST_i));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_ar(input bit m, input logic [4:0] id, input logic [31:0] addr,
                         input logic [2:0] len);
      if (m) begin
         bus.dsp_ARID_i[9:5] = id;     bus.dsp_ARADDR_i[63:32] = addr;
         bus.dsp_ARLEN_i[5:3] = len;   bus.dsp_ARBURST_i[3:2]  = 2'b01;
         bus.dsp_ARSIZE_i[5:3] = 3'd2;
      end else begin
         bus.dsp_ARID_i[4:0] = id;     bus.dsp_ARADDR_i[31:0] = addr;
         bus.dsp_ARLEN_i[2:0] = len;   bus.dsp_ARBURST_i[1:0] = 2'b10;
         bus.dsp_ARSIZE_i[2:0] = 3'd1;
      end
   endtask

   task automatic beat(input logic last, input logic [31:0] d);
      bus.s_RVALID_i = 1'b1;
      bus.s_RLAST_i  = last;
      bus.s_RDATA_i  = d;
      bus.s_RID_i    = d[4:0];
   endtask

   initial begin
      rst_n = 1'b0;
      bus.dsp_ARID_i = '0; bus.dsp_ARADDR_i = '0; bus.dsp_ARBURST_i = '0;
      bus.dsp_ARLEN_i = '0; bus.dsp_ARSIZE_i = '0; bus.dsp_ARVALID_i = '0;
      bus.dsp_RREADY_i = 2'b11; bus.s_ARREADY_i = 1'b1;
      bus.s_RID_i = '0; bus.s_RDATA_i = '0; bus.s_RLAST_i = 1'b0; bus.s_RVALID_i = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      #1;
      check("rst_arvalid", 64'(bus.s_ARVALID_o), 0);
      check("rst_araddr", 64'(bus.s_ARADDR_o), 0);
      check("rst_count", 64'(dut.u_fifo.count_o), 0);

      // single 4-beat read from master 1
      step();
      set_ar(1'b1, 5'd3, 32'h0000_1000, 3'd3);
      bus.dsp_ARVALID_i = 2'b10;
      #1 check("t1_arready", 64'(bus.dsp_ARREADY_o), 2);
      step();
      bus.dsp_ARVALID_i = 2'b00;
      #1 check("t1_s_arvalid", 64'(bus.s_ARVALID_o), 1);
      check("t1_s_arid", 64'(bus.s_ARID_o), 3);
      check("t1_s_arlen", 64'(bus.s_ARLEN_o), 3);
      for (int b = 0; b < 4; b++) begin
         beat(b == 3, 32'hD000_0000 + 32'(b));
         #1 check("t1_rvalid", 64'(bus.dsp_RVALID_o), 2);
         step();
      end
      // beat offered while empty is held off
      beat(1'b0, 32'hE000_0001);
      #1 check("empty_rready", 64'(bus.s_RREADY_o), 0);
      check("empty_rvalid", 64'(bus.dsp_RVALID_o), 0);
      check("t1_count", 64'(dut.u_fifo.count_o), 0);
      check("t1_model_q", 64'(mq.size()), 0);
      bus.s_RVALID_i = 1'b0;

      // contention: alternate grants, then bursts route in grant order
      step();
      set_ar(1'b0, 5'd1, 32'h0000_2000, 3'd1);
      set_ar(1'b1, 5'd2, 32'h0000_3000, 3'd1);
      bus.dsp_ARVALID_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1 check("t2_arready", 64'(bus.dsp_ARREADY_o), (i % 2 == 0) ? 1 : 2);
         step();
      end
      bus.dsp_ARVALID_i = 2'b00;
      check("t2_model_q", 64'(mq.size()), 4);
      for (int j = 0; j < 4; j++) begin
         for (int b = 0; b < 2; b++) begin
            beat(b == 1, 32'hA000_0000 + 32'(j * 16 + b));
            #1 check("t2_rvalid", 64'(bus.dsp_RVALID_o), (j % 2 == 0) ? 1 : 2);
            step();
         end
      end
      bus.s_RVALID_i = 1'b0;

      // AR backpressure: payload frozen, no accept until slave ready
      bus.s_ARREADY_i = 1'b0;
      set_ar(1'b0, 5'd4, 32'h0000_4000, 3'd0);
      bus.dsp_ARVALID_i = 2'b01;
      #1 check("t3_first", 64'(bus.dsp_ARREADY_o), 1);
      step();
      set_ar(1'b1, 5'd5, 32'h0000_5000, 3'd0);
      bus.dsp_ARVALID_i = 2'b10;
      for (int i = 0; i < 5; i++) begin
         #1 check("t3_stall_ready", 64'(bus.dsp_ARREADY_o), 0);
         check("t3_stall_addr", 64'(bus.s_ARADDR_o), 64'h4000);
         check("t3_stall_valid", 64'(bus.s_ARVALID_o), 1);
         step();
      end
      bus.s_ARREADY_i = 1'b1;
      #1 check("t3_release", 64'(bus.dsp_ARREADY_o), 2);
      step();
      bus.dsp_ARVALID_i = 2'b00;
      #1 check("t3_addr2", 64'(bus.s_ARADDR_o), 64'h5000);
      for (int j = 0; j < 2; j++) begin
         beat(1'b1, 32'hB000_0000 + 32'(j));
         #1 check("t3_rvalid", 64'(bus.dsp_RVALID_o), (j == 0) ? 1 : 2);
         step();
      end
      bus.s_RVALID_i = 1'b0;

      // fill all 8 outstanding slots
      bus.dsp_ARVALID_i = 2'b01;
      for (int k = 0; k < 8; k++) begin
         set_ar(1'b0, 5'd6, 32'h0000_6000 + 32'(k * 16), 3'd0);
         #1 check("t4_fill", 64'(bus.dsp_ARREADY_o), 1);
         step();
      end
      #1 check("t4_full", 64'(bus.dsp_ARREADY_o), 0);
      check("t4_count", 64'(dut.u_fifo.count_o), 8);
      beat(1'b1, 32'hC000_0000);
      #1 check("t4_full_pop", 64'(bus.dsp_ARREADY_o), 0);
      check("t4_pop_rvalid", 64'(bus.dsp_RVALID_o), 1);
      step();
      bus.s_RVALID_i = 1'b0;
      #1 check("t4_resume", 64'(bus.dsp_ARREADY_o), 1);
      step();
      bus.dsp_ARVALID_i = 2'b00;
      for (int k = 0; k < 8; k++) begin
         beat(1'b1, 32'hC000_0100 + 32'(k));
         step();
      end
      bus.s_RVALID_i = 1'b0;
      #1 check("t4_drained", 64'(dut.u_fifo.count_o), 0);

      // simultaneous push and pop at count 4
      set_ar(1'b0, 5'd8, 32'h0000_8000, 3'd0);
      set_ar(1'b1, 5'd9, 32'h0000_9000, 3'd0);
      bus.dsp_ARVALID_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1 check("t5_arready", 64'(bus.dsp_ARREADY_o), (i % 2 == 0) ? 2 : 1);
         step();
      end
      beat(1'b1, 32'hF000_0000);
      #1 check("t5_head", 64'(bus.dsp_RVALID_o), 2);
      check("t5_pushpop", 64'(bus.dsp_ARREADY_o), 2);
      step();
      bus.dsp_ARVALID_i = 2'b00;
      bus.s_RVALID_i = 1'b0;
      #1 check("t5_count", 64'(dut.u_fifo.count_o), 4);
      for (int j = 0; j < 4; j++) begin
         beat(1'b1, 32'hF000_0010 + 32'(j));
         #1 check("t5_rvalid", 64'(bus.dsp_RVALID_o), (j % 2 == 0) ? 1 : 2);
         step();
      end
      bus.s_RVALID_i = 1'b0;

      // reset in the middle of a burst
      bus.s_ARREADY_i = 1'b0;
      set_ar(1'b0, 5'd7, 32'h0000_7000, 3'd3);
      bus.dsp_ARVALID_i = 2'b01;
      step();
      bus.dsp_ARVALID_i = 2'b00;
      beat(1'b0, 32'h1234_5678);
      #1 check("t6_rvalid", 64'(bus.dsp_RVALID_o), 1);
      step();
      #1 check("t6_held", 64'(bus.s_ARVALID_o), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_arvalid", 64'(bus.s_ARVALID_o), 0);
      check("t6_rst_araddr", 64'(bus.s_ARADDR_o), 0);
      check("t6_rst_rvalid", 64'(bus.dsp_RVALID_o), 0);
      check("t6_rst_rready", 64'(bus.s_RREADY_o), 0);
      check("t6_rst_arready", 64'(bus.dsp_ARREADY_o), 0);
      check("t6_model_q", 64'(mq.size()), 0);
      step();
      step();
      rst_n = 1'b1;
      bus.s_RVALID_i = 1'b0;
      bus.s_ARREADY_i = 1'b1;
      bus.dsp_ARVALID_i = 2'b11;
      #1 check("t6_ptr0", 64'(bus.dsp_ARREADY_o), 1);
      step();
      bus.dsp_ARVALID_i = 2'b00;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sa_read_channel.md
Name: sa_read_channel

Overview:
Slave-side read arbitration block of the AXI4 interconnect. One instance per slave port.
- Accepts read-address requests from MST_AMT master dispatchers and round-robin arbitrates them onto a single slave AR port.
- Records each grant's master index in an in-order tracking FIFO.
- Steers returning R beats back to the dispatcher at the FIFO head until RLAST.

Parameters:
MST_AMT, 2, number of master dispatchers served
OUTSTANDING_AMT, 8, max AR granted but not completed by an RLAST handshake (tracking FIFO depth)
DATA_WIDTH, 32, RDATA width
ADDR_WIDTH, 32, ARADDR width
TRANS_MST_ID_W, 5, ARID/RID width
TRANS_BURST_W, 2, ARBURST width
TRANS_DATA_LEN_W, 3, ARLEN width
TRANS_DATA_SIZE_W, 3, ARSIZE width
MST_ID_W, $clog2(MST_AMT), master index width (minimum 1)

Ports:
ACLK_i  in  1  clock; single clock domain
ARESETn_i  in  1  asynchronous reset, active-low
dsp_ARID_i  in  TRANS_MST_ID_W*MST_AMT  per-master ARID; master k occupies slice k
dsp_ARADDR_i  in  ADDR_WIDTH*MST_AMT  per-master ARADDR
dsp_ARBURST_i  in  TRANS_BURST_W*MST_AMT  per-master ARBURST
dsp_ARLEN_i  in  TRANS_DATA_LEN_W*MST_AMT  per-master ARLEN
dsp_ARSIZE_i  in  TRANS_DATA_SIZE_W*MST_AMT  per-master ARSIZE
dsp_ARVALID_i  in  MST_AMT  per-master request valid
dsp_ARREADY_o  out  MST_AMT  one-hot grant/accept
dsp_RID_o  out  TRANS_MST_ID_W  RID, broadcast to all masters
dsp_RDATA_o  out  DATA_WIDTH  RDATA, broadcast to all masters
dsp_RLAST_o  out  1  RLAST, broadcast to all masters
dsp_RVALID_o  out  MST_AMT  RVALID, asserted only to the head master
dsp_RREADY_i  in  MST_AMT  per-master RREADY
s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o  out  widths per parameters  registered AR to slave
s_ARVALID_o  out  1  registered AR valid
s_ARREADY_i  in  1  slave AR ready
s_RID_i  in  TRANS_MST_ID_W  slave RID
s_RDATA_i  in  DATA_WIDTH  slave RDATA
s_RLAST_i  in  1  slave RLAST
s_RVALID_i  in  1  slave RVALID
s_RREADY_o  out  1  slave RREADY

Behaviour:
- Reset (async assert, sync release):
  - s_ARVALID_o=0; all s_AR* payload registers =0.
  - FIFO empty, count=0.
  - Round-robin pointer=0, so master 0 has highest priority first.
- AR stage is a one-entry output register. load_ok = !s_ARVALID_o | s_ARREADY_i.
- Grant condition: load_ok & (count < OUTSTANDING_AMT) & |dsp_ARVALID_i. Full is evaluated on count before any same-cycle pop.
- Arbitration:
  - Pick the first requester at or after the pointer, wrapping modulo MST_AMT.
  - dsp_ARREADY_o[g]=1 combinationally in that cycle; all other bits 0.
  - Every bit is 0 when no grant occurs.
- On a grant edge:
  - Load slice g into s_AR*; s_ARVALID_o=1.
  - Push g into the FIFO.
  - Pointer becomes g+1 (wrapping to 0 after MST_AMT-1).
- Latency: AR accepted at cycle N drives s_ARVALID_o at N+1. Back-to-back grants give 1 AR per cycle while s_ARREADY_i=1.
- If s_ARREADY_i=1 with no grant, s_ARVALID_o returns to 0. While s_ARVALID_o=1 and !s_ARREADY_i, the payload holds stable.
- R routing, all combinational (h = FIFO head):
  - dsp_RVALID_o[h] = s_RVALID_i & !empty; all other bits 0.
  - s_RREADY_o = dsp_RREADY_i[h] & !empty.
  - RID/RDATA/RLAST are passed straight through.
- Pop occurs on s_RVALID_i & s_RREADY_o & s_RLAST_i.
  - Simultaneous push and pop: count unchanged, head advances.
  - A full FIFO with a pop this cycle still blocks the grant; accept is re-enabled the next cycle.
- R beat while empty: s_RREADY_o=0. The slave stalls; no beat is dropped or misrouted.
- Non-LAST beats never pop.
- Interleaved read data from the slave is not supported: the slave must return bursts in AR order.
- FIFO pointers wrap modulo OUTSTANDING_AMT. count width is $clog2(OUTSTANDING_AMT+1).
- Reset mid-burst discards all outstanding tracking; outputs return to reset values immediately.

Decomposition:
- Shared interconnect package or header: MST_ID_W derivation, slice-extract helper for the packed per-master buses.
- Sub-module sa_order_fifo: synchronous FIFO of MST_ID_W-bit entries, depth OUTSTANDING_AMT, with push/pop/head/count/full/empty outputs.
- Arbiter stays inline.

Test Plan:
- Single read: master1 ARID=3, ARLEN=3; slave returns 4 beats, the last with RLAST -> dsp_ARREADY_o=2'b10 in the accept cycle, s_ARVALID_o=1 next cycle; dsp_RVALID_o=2'b10 on all 4 beats; count returns to 0.
- Contention: both masters request continuously with s_ARREADY_i=1 -> grants alternate 01,10,01,10; FIFO contents 0,1,0,1; R bursts route in that order.
- Backpressure: s_ARREADY_i=0 for 5 cycles with s_ARVALID_o=1 -> payload stable, dsp_ARREADY_o=0; after release, next grant in the same cycle.
- Outstanding full: issue 8 single-beat ARs with no R -> 9th request sees ARREADY=0. RLAST beat accepted -> grant resumes the following cycle.
- Simultaneous push/pop at count=4 -> count stays 4, head advances, routing correct.
- Empty/reset: s_RVALID_i=1 with FIFO empty -> s_RREADY_o=0, dsp_RVALID_o=0. Assert ARESETn_i mid-burst -> all outputs 0 asynchronously, pointer=0.
